// File: rtl/pc_stack_unit_pkg.sv
// Shared definitions for the program-counter stage: op encoding, default
// parameters and the modulo-2^WIDTH PC increment helper.
// Imported by the interface, the return-stack sub-module and the top.
package pc_stack_unit_pkg;

  // Default datapath width, stack depth, reset PC and sequential step
  localparam int          PSU_WIDTH    = 16;
  localparam int          PSU_DEPTH    = 4;
  localparam int          PSU_DEPTH_W  = $clog2(PSU_DEPTH) + 1;
  localparam logic [15:0] PSU_RESET_PC = 16'h0000;
  localparam int          PSU_INC      = 2;

  // Next-PC operation selector
  typedef enum logic [1:0] {
    OP_SEQ    = 2'b00,
    OP_BRANCH = 2'b01,
    OP_CALL   = 2'b10,
    OP_RET    = 2'b11
  } op_e;

  // PC + INC; the carry out of bit 15 is dropped, so 16'hFFFE + 2 gives 16'h0000
  function automatic logic [15:0] pc_inc(input logic [15:0] pc, input int inc);
    return pc + inc[15:0];
  endfunction

endpackage

// File: rtl/pc_stack_unit_if.sv
// Bundle between the PC stage and its user.
// master: drives pc_write/op/taken/target, observes PC, mux inputs and stack status.
// slave : the PC stage itself (pc_stack_unit).
interface pc_stack_unit_if
  import pc_stack_unit_pkg::*;
#(
  parameter int WIDTH   = PSU_WIDTH,
  parameter int DEPTH_W = PSU_DEPTH_W
);
  // Control / request side
  logic             pc_write;
  op_e              op;
  logic             taken;
  logic [WIDTH-1:0] target;
  // PC and next-PC mux inputs
  logic [WIDTH-1:0] pc;
  logic [WIDTH-1:0] pc_next;
  logic [WIDTH-1:0] branch_target;
  // Return-stack status
  logic [WIDTH-1:0]   stack_top;
  logic [DEPTH_W-1:0] stack_depth;
  logic               stack_empty;
  logic               stack_full;
  logic               fault;

  modport master (
    output pc_write, op, taken, target,
    input  pc, pc_next, branch_target,
    input  stack_top, stack_depth, stack_empty, stack_full, fault
  );

  modport slave (
    input  pc_write, op, taken, target,
    output pc, pc_next, branch_target,
    output stack_top, stack_depth, stack_empty, stack_full, fault
  );

endinterface

// File: rtl/pc_stack_unit_lifo_stack.sv
// Return-address LIFO: WIDTH x DEPTH register array with an occupancy counter.
// Ports: clk, rst_n (async active-low), push/din write entry[depth], pop drops
//   entry[depth-1]; top (0 when empty), depth, full, empty.
module pc_stack_unit_lifo_stack
  import pc_stack_unit_pkg::*;
#(
  parameter int WIDTH   = PSU_WIDTH,
  parameter int DEPTH   = PSU_DEPTH,
  parameter int DEPTH_W = $clog2(DEPTH) + 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               push,
  input  logic               pop,
  input  logic [WIDTH-1:0]   din,
  output logic [WIDTH-1:0]   top,
  output logic [DEPTH_W-1:0] depth,
  output logic               full,
  output logic               empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0]   mem [DEPTH];
  logic [DEPTH_W-1:0] cnt;
  logic [AW-1:0]      top_idx;

  assign empty = (cnt == '0);
  assign full  = (cnt == DEPTH_W'(DEPTH));

  // Low bits of cnt minus one: at cnt==DEPTH the low bits are 0 and wrap to
  // DEPTH-1, which is exactly the top entry because DEPTH is a power of two.
  assign top_idx = cnt[AW-1:0] - AW'(1);
  assign top     = empty ? '0 : mem[top_idx];
  assign depth   = cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (push && !full) begin
      mem[cnt[AW-1:0]] <= din;
      cnt              <= cnt + DEPTH_W'(1);
    end else if (pop && !empty) begin
      // Popped entries keep their old value; top masks them via cnt.
      cnt <= cnt - DEPTH_W'(1);
    end
  end

endmodule

// File: rtl/pc_stack_unit.sv
// Program-counter stage: architectural PC register, PC+INC incrementer, op
//   decode, sticky over/underflow fault and a return-address LIFO.
// Ports: clk, rst_n (async active-low, wins over everything), bus (slave):
//   pc_write/op/taken/target in; pc, pc_next (mux A), branch_target (mux B),
//   stack_top/stack_depth/stack_empty/stack_full, fault out.
module pc_stack_unit
  import pc_stack_unit_pkg::*;
#(
  parameter int               WIDTH    = PSU_WIDTH,
  parameter int               DEPTH    = PSU_DEPTH,
  parameter logic [WIDTH-1:0] RESET_PC = PSU_RESET_PC,
  parameter int               INC      = PSU_INC
) (
  input  logic            clk,
  input  logic            rst_n,
  pc_stack_unit_if.slave  bus
);

  localparam int DEPTH_W = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0]   pc_q;
  logic [WIDTH-1:0]   pc_d;
  logic [WIDTH-1:0]   pc_plus;
  logic               fault_q;
  logic               fault_set;
  logic               do_push;
  logic               do_pop;
  logic [WIDTH-1:0]   stk_top;
  logic [DEPTH_W-1:0] stk_depth;
  logic               stk_full;
  logic               stk_empty;

  assign pc_plus = pc_q + WIDTH'(INC);

  // Next-state decode. Nothing here matters unless pc_write is high, so
  // op/taken/target are only meaningful on enabled edges.
  always_comb begin
    pc_d      = pc_q;
    do_push   = 1'b0;
    do_pop    = 1'b0;
    fault_set = 1'b0;
    if (bus.pc_write) begin
      unique case (bus.op)
        OP_SEQ:    pc_d = pc_plus;
        OP_BRANCH: pc_d = bus.taken ? bus.target : pc_plus;
        OP_CALL: begin
          if (stk_full) begin
            // Overflow: PC and stack both hold, only the fault is recorded
            fault_set = 1'b1;
          end else begin
            do_push = 1'b1;
            pc_d    = bus.target;
          end
        end
        OP_RET: begin
          if (stk_empty) begin
            fault_set = 1'b1;
          end else begin
            do_pop = 1'b1;
            pc_d   = stk_top;
          end
        end
        default: pc_d = pc_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q    <= RESET_PC;
      fault_q <= 1'b0;
    end else begin
      pc_q <= pc_d;
      // Sticky: only reset clears it, and it never gates further operation
      if (fault_set) begin
        fault_q <= 1'b1;
      end
    end
  end

  pc_stack_unit_lifo_stack #(
    .WIDTH   (WIDTH),
    .DEPTH   (DEPTH),
    .DEPTH_W (DEPTH_W)
  ) u_stack (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (do_push),
    .pop   (do_pop),
    .din   (pc_plus),
    .top   (stk_top),
    .depth (stk_depth),
    .full  (stk_full),
    .empty (stk_empty)
  );

  assign bus.pc            = pc_q;
  assign bus.pc_next       = pc_plus;
  // Mux input B follows the op combinationally: return address on RET
  assign bus.branch_target = (bus.op == OP_RET) ? stk_top : bus.target;
  assign bus.stack_top     = stk_top;
  assign bus.stack_depth   = stk_depth;
  assign bus.stack_empty   = stk_empty;
  assign bus.stack_full    = stk_full;
  assign bus.fault         = fault_q;

endmodule

// File: tb/tb_pc_stack_unit.sv
module tb_pc_stack_unit;
  import pc_stack_unit_pkg::*;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  pc_stack_unit_if #(.WIDTH(16), .DEPTH_W(3)) bus ();

  pc_stack_unit #(
    .WIDTH    (16),
    .DEPTH    (4),
    .RESET_PC (16'h0000),
    .INC      (2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one set of inputs, take one rising edge, settle 1 time unit after it
  task automatic step(input logic w, input op_e o, input logic t, input logic [15:0] tg);
    bus.pc_write = w;
    bus.op       = o;
    bus.taken    = t;
    bus.target   = tg;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n        = 1'b0;
    bus.pc_write = 1'b1;
    bus.op       = OP_CALL;
    bus.taken    = 1'b1;
    bus.target   = 16'h1234;
    #3;
    n_checks++; if (bus.pc !== 16'h0000) begin n_fail++; $display("FAIL reset_pc: got %h expected 0000", bus.pc); end
    n_checks++; if (bus.pc_next !== 16'h0002) begin n_fail++; $display("FAIL reset_pc_next: got %h expected 0002", bus.pc_next); end
    n_checks++; if (bus.stack_empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty: got %b expected 1", bus.stack_empty); end
    n_checks++; if (bus.stack_full !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %b expected 0", bus.stack_full); end
    n_checks++; if (bus.fault !== 1'b0) begin n_fail++; $display("FAIL reset_fault: got %b expected 0", bus.fault); end
    n_checks++; if (bus.stack_depth !== 3'd0) begin n_fail++; $display("FAIL reset_depth: got %0d expected 0", bus.stack_depth); end
    n_checks++; if (bus.stack_top !== 16'h0000) begin n_fail++; $display("FAIL reset_top: got %h expected 0000", bus.stack_top); end
    // A clock edge with an enabled CALL while in reset must change nothing
    @(posedge clk); #1;
    n_checks++; if (bus.pc !== 16'h0000 || bus.stack_depth !== 3'd0) begin
      n_fail++; $display("FAIL reset_wins: pc %h depth %0d expected 0000/0", bus.pc, bus.stack_depth);
    end
    bus.pc_write = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_seq();
    for (int i = 1; i <= 3; i++) begin
      step(1'b1, OP_SEQ, 1'b0, 16'h0000);
      n_checks++; if (bus.pc !== 16'(2 * i)) begin n_fail++; $display("FAIL seq_%0d: got %h expected %h", i, bus.pc, 16'(2 * i)); end
    end
    step(1'b0, OP_CALL, 1'b1, 16'hBEEF);
    step(1'b0, OP_RET, 1'b1, 16'hBEEF);
    n_checks++; if (bus.pc !== 16'h0006) begin n_fail++; $display("FAIL seq_hold: got %h expected 0006", bus.pc); end
    n_checks++; if (bus.pc_next !== 16'h0008) begin n_fail++; $display("FAIL seq_hold_next: got %h expected 0008", bus.pc_next); end
    n_checks++; if (bus.stack_depth !== 3'd0 || bus.fault !== 1'b0) begin
      n_fail++; $display("FAIL seq_hold_stack: depth %0d fault %b expected 0/0", bus.stack_depth, bus.fault);
    end
  endtask

  task automatic test_branch();
    bus.op     = OP_BRANCH;
    bus.target = 16'h0100;
    #1;
    n_checks++; if (bus.branch_target !== 16'h0100) begin n_fail++; $display("FAIL br_mux_b: got %h expected 0100", bus.branch_target); end
    step(1'b1, OP_BRANCH, 1'b1, 16'h0100);
    n_checks++; if (bus.pc !== 16'h0100) begin n_fail++; $display("FAIL br_taken: got %h expected 0100", bus.pc); end
    step(1'b1, OP_BRANCH, 1'b0, 16'h0300);
    n_checks++; if (bus.pc !== 16'h0102) begin n_fail++; $display("FAIL br_not_taken: got %h expected 0102", bus.pc); end
  endtask

  task automatic test_call_ret();
    step(1'b1, OP_BRANCH, 1'b1, 16'h0010);
    step(1'b1, OP_CALL, 1'b0, 16'h0200);
    n_checks++; if (bus.pc !== 16'h0200) begin n_fail++; $display("FAIL call_pc: got %h expected 0200", bus.pc); end
    n_checks++; if (bus.stack_top !== 16'h0012) begin n_fail++; $display("FAIL call_top: got %h expected 0012", bus.stack_top); end
    n_checks++; if (bus.stack_depth !== 3'd1 || bus.stack_empty !== 1'b0) begin
      n_fail++; $display("FAIL call_depth: depth %0d empty %b expected 1/0", bus.stack_depth, bus.stack_empty);
    end
    bus.op     = OP_RET;
    bus.target = 16'h7777;
    #1;
    n_checks++; if (bus.branch_target !== 16'h0012) begin n_fail++; $display("FAIL ret_mux_b: got %h expected 0012", bus.branch_target); end
    step(1'b1, OP_RET, 1'b0, 16'h7777);
    n_checks++; if (bus.pc !== 16'h0012) begin n_fail++; $display("FAIL ret_pc: got %h expected 0012", bus.pc); end
    n_checks++; if (bus.stack_empty !== 1'b1 || bus.stack_top !== 16'h0000) begin
      n_fail++; $display("FAIL ret_empty: empty %b top %h expected 1/0000", bus.stack_empty, bus.stack_top);
    end
  endtask

  task automatic test_overflow();
    logic [15:0] tgt [4];
    logic [15:0] ret [4];
    tgt = '{16'h2000, 16'h3000, 16'h4000, 16'h5000};
    ret = '{16'h1002, 16'h2002, 16'h3002, 16'h4002};
    step(1'b1, OP_BRANCH, 1'b1, 16'h1000);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, OP_CALL, 1'b0, tgt[i]);
      n_checks++; if (bus.pc !== tgt[i] || bus.stack_top !== ret[i] || bus.stack_depth !== 3'(i + 1)) begin
        n_fail++; $display("FAIL ovf_call_%0d: pc %h top %h depth %0d expected %h/%h/%0d",
                           i, bus.pc, bus.stack_top, bus.stack_depth, tgt[i], ret[i], i + 1);
      end
    end
    n_checks++; if (bus.stack_full !== 1'b1 || bus.fault !== 1'b0) begin
      n_fail++; $display("FAIL ovf_full: full %b fault %b expected 1/0", bus.stack_full, bus.fault);
    end
    step(1'b1, OP_CALL, 1'b0, 16'h6000);
    n_checks++; if (bus.pc !== 16'h5000 || bus.fault !== 1'b1 || bus.stack_depth !== 3'd4 || bus.stack_top !== 16'h4002) begin
      n_fail++; $display("FAIL ovf_5th_call: pc %h fault %b depth %0d top %h expected 5000/1/4/4002",
                         bus.pc, bus.fault, bus.stack_depth, bus.stack_top);
    end
    for (int i = 3; i >= 0; i--) begin
      step(1'b1, OP_RET, 1'b0, 16'h0000);
      n_checks++; if (bus.pc !== ret[i] || bus.stack_depth !== 3'(i)) begin
        n_fail++; $display("FAIL unf_ret_%0d: pc %h depth %0d expected %h/%0d", i, bus.pc, bus.stack_depth, ret[i], i);
      end
    end
    step(1'b1, OP_RET, 1'b0, 16'h0000);
    n_checks++; if (bus.pc !== 16'h1002 || bus.fault !== 1'b1 || bus.stack_empty !== 1'b1) begin
      n_fail++; $display("FAIL unf_5th_ret: pc %h fault %b empty %b expected 1002/1/1", bus.pc, bus.fault, bus.stack_empty);
    end
    // Fault does not block normal operation
    step(1'b1, OP_SEQ, 1'b0, 16'h0000);
    n_checks++; if (bus.pc !== 16'h1004 || bus.fault !== 1'b1) begin
      n_fail++; $display("FAIL fault_sticky_seq: pc %h fault %b expected 1004/1", bus.pc, bus.fault);
    end
  endtask

  task automatic test_wrap_reset();
    step(1'b1, OP_BRANCH, 1'b1, 16'hFFFE);
    n_checks++; if (bus.pc_next !== 16'h0000) begin n_fail++; $display("FAIL wrap_next: got %h expected 0000", bus.pc_next); end
    step(1'b1, OP_SEQ, 1'b0, 16'h0000);
    n_checks++; if (bus.pc !== 16'h0000) begin n_fail++; $display("FAIL wrap_pc: got %h expected 0000", bus.pc); end
    step(1'b1, OP_CALL, 1'b0, 16'h0A00);
    step(1'b1, OP_CALL, 1'b0, 16'h0B00);
    n_checks++; if (bus.stack_depth !== 3'd2 || bus.pc !== 16'h0B00) begin
      n_fail++; $display("FAIL pre_rst: depth %0d pc %h expected 2/0B00", bus.stack_depth, bus.pc);
    end
    // Mid-cycle reset while a CALL is presented, then check before any edge
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++; if (bus.pc !== 16'h0000 || bus.stack_depth !== 3'd0 || bus.stack_empty !== 1'b1) begin
      n_fail++; $display("FAIL async_rst: pc %h depth %0d empty %b expected 0000/0/1", bus.pc, bus.stack_depth, bus.stack_empty);
    end
    n_checks++; if (bus.fault !== 1'b0 || bus.stack_top !== 16'h0000) begin
      n_fail++; $display("FAIL async_rst_fault: fault %b top %h expected 0/0000", bus.fault, bus.stack_top);
    end
    bus.pc_write = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, OP_SEQ, 1'b0, 16'h0000);
    n_checks++; if (bus.pc !== 16'h0002) begin n_fail++; $display("FAIL post_rst_seq: got %h expected 0002", bus.pc); end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_seq();
    test_branch();
    test_call_ret();
    test_overflow();
    test_wrap_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
